// File: rtl/mnacidpro_sequencer_pkg.sv
// Shared definitions for the mnacidpro protocol sequencer.
//   state_e        : sequencer states (exported on the debug port)
//   V_*            : bit positions inside the 11-bit valve_ctrl word
//   VALVES_SAFE    : every valve line pressurised (all valves closed)
//   OPEN_*         : per-state masks of valves that are open (line driven 0)
//   PUMP_*         : peristaltic pump line patterns
// Polarity reminder: 1 = line pressurised = valve closed.
package mnacidpro_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BEAD_LOAD,
        ST_CELL_LOAD,
        ST_LYSIS,
        ST_MIX,
        ST_WASH,
        ST_ELUTE,
        ST_COLLECT,
        ST_FLUSH,
        ST_SAFE
    } state_e;

    localparam int V_LYSIS     = 10;
    localparam int V_WASH      = 9;
    localparam int V_ELUTE     = 8;
    localparam int V_DEAD_END  = 7;
    localparam int V_VERTICAL  = 6;
    localparam int V_HORIZ     = 5;
    localparam int V_WASTE     = 4;
    localparam int V_BEAD      = 3;
    localparam int V_LOOP_EXIT = 2;
    localparam int V_BEAD_TRAP = 1;
    localparam int V_COLLECT   = 0;

    localparam logic [10:0] VALVES_SAFE = 11'h7FF;

    localparam logic [10:0] OPEN_BEAD_LOAD = (11'd1 << V_BEAD) | (11'd1 << V_HORIZ) |
                                             (11'd1 << V_BEAD_TRAP) | (11'd1 << V_WASTE);
    localparam logic [10:0] OPEN_CELL_LOAD = (11'd1 << V_VERTICAL) | (11'd1 << V_DEAD_END) |
                                             (11'd1 << V_WASTE);
    localparam logic [10:0] OPEN_LYSIS     = (11'd1 << V_LYSIS) | (11'd1 << V_VERTICAL) |
                                             (11'd1 << V_LOOP_EXIT);
    localparam logic [10:0] OPEN_MIX       = (11'd1 << V_LOOP_EXIT) | (11'd1 << V_HORIZ);
    localparam logic [10:0] OPEN_WASH      = (11'd1 << V_WASH) | (11'd1 << V_HORIZ) |
                                             (11'd1 << V_BEAD_TRAP) | (11'd1 << V_WASTE);
    localparam logic [10:0] OPEN_ELUTE     = (11'd1 << V_ELUTE) | (11'd1 << V_HORIZ) |
                                             (11'd1 << V_BEAD_TRAP);
    localparam logic [10:0] OPEN_COLLECT   = (11'd1 << V_LOOP_EXIT) | (11'd1 << V_BEAD_TRAP) |
                                             (11'd1 << V_COLLECT);
    localparam logic [10:0] OPEN_FLUSH     = (11'd1 << V_WASH) | (11'd1 << V_VERTICAL) |
                                             (11'd1 << V_HORIZ) | (11'd1 << V_WASTE);

    localparam logic [2:0] PUMP_IDLE = 3'b111;
    localparam logic [2:0] PUMP_PH0  = 3'b011;
    localparam logic [2:0] PUMP_PH1  = 3'b101;
    localparam logic [2:0] PUMP_PH2  = 3'b110;

    // Valves that are open in a given state; IDLE and SAFE open nothing.
    function automatic logic [10:0] open_mask(input state_e s);
        case (s)
            ST_BEAD_LOAD: return OPEN_BEAD_LOAD;
            ST_CELL_LOAD: return OPEN_CELL_LOAD;
            ST_LYSIS:     return OPEN_LYSIS;
            ST_MIX:       return OPEN_MIX;
            ST_WASH:      return OPEN_WASH;
            ST_ELUTE:     return OPEN_ELUTE;
            ST_COLLECT:   return OPEN_COLLECT;
            ST_FLUSH:     return OPEN_FLUSH;
            default:      return 11'h000;
        endcase
    endfunction

    // Width of the fraction index; kept at least 1 bit so SIZE=1 still builds.
    function automatic int frac_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mnacidpro_sequencer_if.sv
// Host-side bundle of the mnacidpro sequencer.
//   start      host -> seq   1-cycle run request
//   abort      host -> seq   level, forces SAFE
//   busy       seq -> host   high outside IDLE
//   done       seq -> host   1-cycle pulse at end of a completed run
//   frac_idx   seq -> host   current elution fraction
//   valve_ctrl seq -> chip   11 valve lines (1 = closed)
//   pump       seq -> chip   3 pump lines
//   dbg_state  seq -> debug  current FSM state
// Handshake: start is a single-cycle request sampled on the rising edge;
// it is accepted only when busy is low, otherwise dropped without effect.
// There is no ready/ack; busy rising on the next edge is the acceptance.
interface mnacidpro_sequencer_if #(
    parameter int SIZE = 5
);
    import mnacidpro_seq_pkg::*;

    localparam int FRAC_W = frac_width(SIZE);

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [FRAC_W-1:0] frac_idx;
    logic [10:0]       valve_ctrl;
    logic [2:0]        pump;
    state_e            dbg_state;

    modport master (
        output start, abort,
        input  busy, done, frac_idx, valve_ctrl, pump, dbg_state
    );

    modport slave (
        input  start, abort,
        output busy, done, frac_idx, valve_ctrl, pump, dbg_state
    );

endinterface

// File: rtl/mnacidpro_sequencer_pump_phaser.sv
// Three-phase peristaltic pump driver.
//   clk, rst  : clock, synchronous active-high reset
//   i_en      : run request; low forces the pump to 111 and rewinds to phase 0
//   o_pump    : pump lines, 011 -> 101 -> 110 -> repeat, PUMP_DIV cycles each
// i_en is the "next state is MIX" decision, so the first phase appears on the
// same edge the sequencer enters MIX and the pump idles on the exit edge.
module mnacidpro_pump_phaser
    import mnacidpro_seq_pkg::*;
#(
    parameter int PUMP_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [2:0] o_pump
);
    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

    logic             r_active;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_phase;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_phase  <= 2'd0;
        end else if (!r_active) begin
            r_active <= 1'b1;
            r_div    <= '0;
            r_phase  <= 2'd0;
        end else if (r_div == DIV_W'(PUMP_DIV - 1)) begin
            r_div   <= '0;
            r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        o_pump = PUMP_IDLE;
        if (r_active) begin
            case (r_phase)
                2'd0:    o_pump = PUMP_PH0;
                2'd1:    o_pump = PUMP_PH1;
                2'd2:    o_pump = PUMP_PH2;
                default: o_pump = PUMP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mnacidpro_sequencer.sv
// Protocol sequencer for the mnacidpro purification chip.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mnacidpro_sequencer_if (start/abort in;
//              busy/done/frac_idx/valve_ctrl/pump/dbg_state out)
// Runs bead load, cell load, lysis, mix, wash, SIZE elute/collect pairs and
// a flush. All outputs are registered from the next-state decision so the
// valve pattern changes on the same edge as the state.
module mnacidpro_sequencer
    import mnacidpro_seq_pkg::*;
#(
    parameter int SIZE      = 5,
    parameter int T_LOAD    = 200,
    parameter int T_LYSIS   = 400,
    parameter int MIX_ROT   = 8,
    parameter int T_WASH    = 300,
    parameter int T_ELUTE   = 150,
    parameter int T_COLLECT = 100,
    parameter int PUMP_DIV  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    mnacidpro_sequencer_if.slave  bus
);
    localparam int FRAC_W = frac_width(SIZE);
    localparam int T_MIX  = 3 * PUMP_DIV * MIX_ROT;
    localparam int T_MAX  = max_int(max_int(max_int(T_LOAD, T_LYSIS), max_int(T_MIX, T_WASH)),
                                    max_int(T_ELUTE, T_COLLECT));
    localparam int CNT_W  = $clog2(T_MAX + 1);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_limit;
    logic              w_expired;
    logic              w_last_frac;
    logic [FRAC_W-1:0] r_frac;
    logic [10:0]       r_valve;
    logic              r_busy;
    logic              r_done;
    logic [2:0]        w_pump;

    // Last count value of the current timed state.
    always_comb begin
        w_limit = '0;
        case (r_state)
            ST_BEAD_LOAD, ST_CELL_LOAD: w_limit = CNT_W'(T_LOAD - 1);
            ST_LYSIS:                   w_limit = CNT_W'(T_LYSIS - 1);
            ST_MIX:                     w_limit = CNT_W'(T_MIX - 1);
            ST_WASH, ST_FLUSH:          w_limit = CNT_W'(T_WASH - 1);
            ST_ELUTE:                   w_limit = CNT_W'(T_ELUTE - 1);
            ST_COLLECT:                 w_limit = CNT_W'(T_COLLECT - 1);
            default:                    w_limit = '0;
        endcase
    end

    assign w_expired   = (r_cnt == w_limit);
    assign w_last_frac = (r_frac == FRAC_W'(SIZE - 1));

    // Next-state logic; abort outranks timer expiry in every active state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_BEAD_LOAD;
            end
            ST_SAFE: begin
                if (!bus.abort) w_next = ST_IDLE;
            end
            default: begin
                if (bus.abort) begin
                    w_next = ST_SAFE;
                end else if (w_expired) begin
                    case (r_state)
                        ST_BEAD_LOAD: w_next = ST_CELL_LOAD;
                        ST_CELL_LOAD: w_next = ST_LYSIS;
                        ST_LYSIS:     w_next = ST_MIX;
                        ST_MIX:       w_next = ST_WASH;
                        ST_WASH:      w_next = ST_ELUTE;
                        ST_ELUTE:     w_next = ST_COLLECT;
                        ST_COLLECT:   w_next = w_last_frac ? ST_FLUSH : ST_ELUTE;
                        ST_FLUSH:     w_next = ST_IDLE;
                        default:      w_next = ST_SAFE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Step counter restarts on every state change (including COLLECT->ELUTE)
    // and stays at 0 in the untimed IDLE/SAFE states so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_frac  <= '0;
            r_valve <= VALVES_SAFE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if ((w_next != r_state) || (w_next == ST_IDLE) || (w_next == ST_SAFE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_next == ST_IDLE) begin
                r_frac <= '0;
            end else if ((r_state == ST_COLLECT) && (w_next == ST_ELUTE)) begin
                r_frac <= r_frac + 1'b1;
            end

            r_valve <= ~open_mask(w_next);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_FLUSH) && (w_next == ST_IDLE);
        end
    end

    mnacidpro_pump_phaser #(
        .PUMP_DIV (PUMP_DIV)
    ) u_phaser (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_next == ST_MIX),
        .o_pump (w_pump)
    );

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.frac_idx   = r_frac;
    assign bus.valve_ctrl = r_valve;
    assign bus.pump       = w_pump;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// Randomized self-checking bench for mnacidpro_sequencer (shrunk timings).
// The reference model expands the protocol table into a per-cycle list of
// expected outputs (valves, pump, busy, done, frac_idx) and the bench pops
// one entry per clock.
module tb_mnacidpro_sequencer;

  localparam int SIZE      = 3;
  localparam int T_LOAD    = 4;
  localparam int T_LYSIS   = 4;
  localparam int MIX_ROT   = 2;
  localparam int T_WASH    = 4;
  localparam int T_ELUTE   = 4;
  localparam int T_COLLECT = 4;
  localparam int PUMP_DIV  = 2;

  localparam int FW      = $clog2(SIZE);
  localparam int EW      = 11 + 3 + 1 + 1 + FW;
  localparam int T_MIX   = 3 * PUMP_DIV * MIX_ROT;
  localparam int RUN_LEN = 2 * T_LOAD + T_LYSIS + T_MIX + T_WASH
                           + SIZE * (T_ELUTE + T_COLLECT) + T_WASH;
  localparam int MIX_AT  = 2 * T_LOAD + T_LYSIS;
  // First cycle of the second COLLECT step.
  localparam int RST_AT  = MIX_AT + T_MIX + T_WASH + (T_ELUTE + T_COLLECT) + T_ELUTE;

  // Open valves per state, bit order
  // {lysis,wash,elute,dead_end,vertical,horiz,waste,bead,loop_exit,bead_trap,collect}.
  localparam logic [10:0] M_BEAD    = 11'h03A;
  localparam logic [10:0] M_CELL    = 11'h0D0;
  localparam logic [10:0] M_LYSIS   = 11'h444;
  localparam logic [10:0] M_MIX     = 11'h024;
  localparam logic [10:0] M_WASH    = 11'h232;
  localparam logic [10:0] M_ELUTE   = 11'h122;
  localparam logic [10:0] M_COLLECT = 11'h007;
  localparam logic [10:0] M_FLUSH   = 11'h270;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mnacidpro_sequencer_if #(.SIZE(SIZE)) bus ();

  mnacidpro_sequencer #(
    .SIZE      (SIZE),
    .T_LOAD    (T_LOAD),
    .T_LYSIS   (T_LYSIS),
    .MIX_ROT   (MIX_ROT),
    .T_WASH    (T_WASH),
    .T_ELUTE   (T_ELUTE),
    .T_COLLECT (T_COLLECT),
    .PUMP_DIV  (PUMP_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] rec(input logic [10:0] open, input logic [2:0] pump,
                                        input logic busy, input logic done, input int frac);
    logic [FW-1:0] f;
    f = FW'(frac);
    return {~open, pump, busy, done, f};
  endfunction

  task automatic check_entry(input logic [EW-1:0] e);
    check_eq("valve_ctrl", 32'(bus.valve_ctrl), 32'(e[EW-1 -: 11]));
    check_eq("pump",       32'(bus.pump),       32'(e[EW-12 -: 3]));
    check_eq("busy",       32'(bus.busy),       32'(e[FW+1]));
    check_eq("done",       32'(bus.done),       32'(e[FW]));
    check_eq("frac_idx",   32'(bus.frac_idx),   32'(e[FW-1:0]));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valve"}, 32'(bus.valve_ctrl), 32'h7FF);
    check_eq({tag, "_pump"},  32'(bus.pump),       32'h7);
    check_eq({tag, "_busy"},  32'(bus.busy),       32'h0);
    check_eq({tag, "_done"},  32'(bus.done),       32'h0);
    check_eq({tag, "_frac"},  32'(bus.frac_idx),   32'h0);
  endtask

  // ---------------- reference model ----------------
  // Expected outputs for every cycle after the start edge. abort_at < 0
  // means an uninterrupted run; otherwise abort is sampled high after
  // cycle abort_at for abort_len consecutive edges.
  task automatic build_expected(input int abort_at, input int abort_len);
    logic [EW-1:0] run_q[$];
    logic [2:0] pump_seq[3];
    int frac;
    pump_seq[0] = 3'b011;
    pump_seq[1] = 3'b101;
    pump_seq[2] = 3'b110;
    exp_q.delete();
    for (int j = 0; j < T_LOAD; j++)  run_q.push_back(rec(M_BEAD,  3'b111, 1'b1, 1'b0, 0));
    for (int j = 0; j < T_LOAD; j++)  run_q.push_back(rec(M_CELL,  3'b111, 1'b1, 1'b0, 0));
    for (int j = 0; j < T_LYSIS; j++) run_q.push_back(rec(M_LYSIS, 3'b111, 1'b1, 1'b0, 0));
    for (int j = 0; j < T_MIX; j++)
      run_q.push_back(rec(M_MIX, pump_seq[(j / PUMP_DIV) % 3], 1'b1, 1'b0, 0));
    for (int j = 0; j < T_WASH; j++)  run_q.push_back(rec(M_WASH,  3'b111, 1'b1, 1'b0, 0));
    for (int f = 0; f < SIZE; f++) begin
      for (int j = 0; j < T_ELUTE; j++)   run_q.push_back(rec(M_ELUTE,   3'b111, 1'b1, 1'b0, f));
      for (int j = 0; j < T_COLLECT; j++) run_q.push_back(rec(M_COLLECT, 3'b111, 1'b1, 1'b0, f));
    end
    for (int j = 0; j < T_WASH; j++) run_q.push_back(rec(M_FLUSH, 3'b111, 1'b1, 1'b0, SIZE - 1));

    if (abort_at < 0) begin
      foreach (run_q[i]) exp_q.push_back(run_q[i]);
      exp_q.push_back(rec(11'h000, 3'b111, 1'b0, 1'b1, 0));
      exp_q.push_back(rec(11'h000, 3'b111, 1'b0, 1'b0, 0));
    end else begin
      for (int i = 0; i <= abort_at; i++) exp_q.push_back(run_q[i]);
      frac = int'(run_q[abort_at][FW-1:0]);
      for (int i = 0; i < abort_len; i++) exp_q.push_back(rec(11'h000, 3'b111, 1'b1, 1'b0, frac));
      exp_q.push_back(rec(11'h000, 3'b111, 1'b0, 1'b0, 0));
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. rst_at >= 0 asserts rst after
  // that cycle and checks the return to reset values.
  task automatic run_sequence(input int abort_at, input int abort_len, input int rst_at);
    int idx = 0;
    int busy_cnt = 0;
    int exp_busy = 0;
    logic [EW-1:0] e;
    build_expected(abort_at, abort_len);
    foreach (exp_q[i]) exp_busy += int'(exp_q[i][FW+1]);
    bus.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      bus.start = 1'b0;
      check_entry(e);
      busy_cnt += int'(bus.busy);
      if (idx == rst_at) begin
        rst = 1'b1;
        break;
      end
      bus.abort = (abort_at >= 0) && (idx >= abort_at) && (idx < abort_at + abort_len);
      // start while busy must be ignored
      if (e[FW+1] && ($urandom_range(0, 3) == 0)) bus.start = 1'b1;
      idx++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (rst_at >= 0) begin
      exp_q.delete();
      @(negedge clk);
      check_idle("rst_mid");
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_rst");
    end else if (abort_at < 0) begin
      check_eq("busy_total", 32'(busy_cnt), 32'(RUN_LEN));
    end else begin
      check_eq("busy_total_abort", 32'(busy_cnt), 32'(exp_busy));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle");

    run_sequence(-1, 0, -1);

    bus.abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("abort_idle");
    end
    bus.abort = 1'b0;
    @(negedge clk);
    check_idle("abort_idle_rel");

    run_sequence(MIX_AT + 4, 3, -1);
    run_sequence(-1, 0, RST_AT);

    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 1) == 1)
        run_sequence(int'($urandom_range(0, RUN_LEN - 1)), int'($urandom_range(1, 4)), -1);
      else
        run_sequence(-1, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
